// File: rtl/ecc_pkg.sv
// Shared ECC constants and scheduler types: coordinate width, infinity
// encoding, FSM state encoding and point-unit opcodes.
package ecc_pkg;

  localparam int WIDTH = 192;
  localparam int CNT_W = 8;

  // The point at infinity is encoded as all-ones in both coordinates.
  localparam logic [WIDTH-1:0] INF = '1;

  // Point-unit opcodes carried on o_pa_op.
  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/scalar_bit_scanner.sv
// Scalar shift register with a bit-index counter. The scheduler consumes
// bits MSB-first; idx tracks the original position of the bit now at the top.
module scalar_bit_scanner #(
  parameter int WIDTH = 192,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] k_in,
  output logic             msb,
  output logic             zero
);

  logic [WIDTH-1:0] k;
  logic [CNT_W-1:0] idx;

  // Load resets idx to the top bit; each shift consumes one bit. idx
  // saturates at zero so a final shift on the last bit leaves it parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      k   <= '0;
      idx <= '0;
    end else if (load) begin
      k   <= k_in;
      idx <= CNT_W'(WIDTH - 1);
    end else if (shift) begin
      k <= {k[WIDTH-2:0], 1'b0};
      if (idx != '0) idx <= idx - CNT_W'(1);
    end
  end

  assign msb  = k[WIDTH-1];
  assign zero = (idx == '0);

endmodule

// File: rtl/point_mul_scheduler.sv
// MSB-first double-and-add-always scheduler for R = k*P. Drives a shared
// point add/double unit through a start/finish handshake; the number of unit
// operations depends only on the bit length of k, and infinity cases are
// resolved by overriding the unit result rather than skipping requests.
module point_mul_scheduler
  import ecc_pkg::*;
#(
  parameter int WIDTH = ecc_pkg::WIDTH,
  parameter int CNT_W = ecc_pkg::CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_busy,
  output logic             o_finish,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y,
  output logic             o_inf,
  output logic             o_pa_start,
  output logic             o_pa_op,
  output logic             o_pa_add,
  output logic [WIDTH-1:0] o_pa_x1,
  output logic [WIDTH-1:0] o_pa_y1,
  output logic [WIDTH-1:0] o_pa_x2,
  output logic [WIDTH-1:0] o_pa_y2,
  input  logic             i_pa_finish,
  input  logic [WIDTH-1:0] i_pa_x,
  input  logic [WIDTH-1:0] i_pa_y
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] p_x, p_y;
  logic [WIDTH-1:0] r_x, r_y;
  logic             r_inf;
  logic             k_load, k_shift, k_msb, k_zero;

  scalar_bit_scanner #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_scan (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (k_load),
    .shift (k_shift),
    .k_in  (i_k),
    .msb   (k_msb),
    .zero  (k_zero)
  );

  assign r_inf = (r_x == ALL_ONES) && (r_y == ALL_ONES);

  // Operands come straight from the R/P registers; R only changes on a
  // unit finish, so they stay stable for the whole request.
  assign o_pa_x1 = r_x;
  assign o_pa_y1 = r_y;
  assign o_pa_x2 = p_x;
  assign o_pa_y2 = p_y;

  // Busy spans the run plus the finish-pulse cycle; IDLE refuses starts then.
  assign o_busy = (state != S_IDLE) || o_finish;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic, scanner control and point-unit request signals.
  always_comb begin
    state_nxt  = state;
    k_load     = 1'b0;
    k_shift    = 1'b0;
    o_pa_start = 1'b0;
    o_pa_op    = OP_DBL;
    o_pa_add   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start && !o_finish) begin
          k_load    = 1'b1;
          state_nxt = (i_k == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        // Shift until the leading one reaches the top, then one more shift
        // drops it (R already holds P for that bit).
        k_shift = 1'b1;
        if (k_msb) state_nxt = k_zero ? S_DONE : S_DBL_REQ;
      end
      S_DBL_REQ: begin
        o_pa_start = 1'b1;
        o_pa_add   = 1'b1;
        state_nxt  = S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        o_pa_add = 1'b1;
        if (i_pa_finish) state_nxt = S_ADD_REQ;
      end
      S_ADD_REQ: begin
        o_pa_start = 1'b1;
        o_pa_op    = OP_ADD;
        o_pa_add   = k_msb;
        state_nxt  = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        o_pa_op  = OP_ADD;
        o_pa_add = k_msb;
        if (i_pa_finish) begin
          k_shift   = 1'b1;
          state_nxt = k_zero ? S_DONE : S_DBL_REQ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/result registers, infinity overrides and the finish pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_x        <= '0;
      p_y        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      o_result_x <= '0;
      o_result_y <= '0;
      o_inf      <= 1'b0;
      o_finish   <= 1'b0;
    end else begin
      o_finish <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (k_load) begin
            p_x <= i_x;
            p_y <= i_y;
            if (i_k == '0) begin
              r_x <= ALL_ONES;
              r_y <= ALL_ONES;
            end else begin
              r_x <= i_x;
              r_y <= i_y;
            end
          end
        end
        S_DBL_WAIT: begin
          // Doubling infinity stays infinity whatever the unit returned.
          if (i_pa_finish && !r_inf) begin
            r_x <= i_pa_x;
            r_y <= i_pa_y;
          end
        end
        S_ADD_WAIT: begin
          // inf + P = P when the add is committed; otherwise inf remains.
          if (i_pa_finish) begin
            if (r_inf) begin
              if (k_msb) begin
                r_x <= p_x;
                r_y <= p_y;
              end
            end else begin
              r_x <= i_pa_x;
              r_y <= i_pa_y;
            end
          end
        end
        S_DONE: begin
          o_result_x <= r_x;
          o_result_y <= r_y;
          o_inf      <= r_inf;
          o_finish   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_mul_scheduler.sv
// Directed bench for point_mul_scheduler on the toy curve y^2 = x^3+2x+2
// mod 17 with base point P = (5,1) of order 19. A behavioural point unit with
// a fixed 5-cycle latency answers requests and logs (op, add).
module tb_point_mul_scheduler;

  localparam int W = 192;
  localparam logic [W-1:0] ALL1 = '1;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] k, x, y;
  logic         busy, fin, inf;
  logic [W-1:0] res_x, res_y;
  logic         pa_start, pa_op, pa_add;
  logic [W-1:0] pa_x1, pa_y1, pa_x2, pa_y2;
  logic         pa_fin;
  logic [W-1:0] pa_x, pa_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  point_mul_scheduler #(.WIDTH(W), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_k         (k),
    .i_x         (x),
    .i_y         (y),
    .o_busy      (busy),
    .o_finish    (fin),
    .o_result_x  (res_x),
    .o_result_y  (res_y),
    .o_inf       (inf),
    .o_pa_start  (pa_start),
    .o_pa_op     (pa_op),
    .o_pa_add    (pa_add),
    .o_pa_x1     (pa_x1),
    .o_pa_y1     (pa_y1),
    .o_pa_x2     (pa_x2),
    .o_pa_y2     (pa_y2),
    .i_pa_finish (pa_fin),
    .i_pa_x      (pa_x),
    .i_pa_y      (pa_y)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int md(input int v);
    return ((v % 17) + 17) % 17;
  endfunction

  function automatic int inv(input int a);
    for (int i = 1; i < 17; i++) if (md(a * i) == 1) return i;
    return 0;
  endfunction

  // Curve arithmetic for the point-unit model; all-ones means infinity.
  task automatic unit_calc(input logic op, input logic add,
                           input logic [W-1:0] x1, input logic [W-1:0] y1,
                           input logic [W-1:0] x2, input logic [W-1:0] y2,
                           output logic [W-1:0] rx, output logic [W-1:0] ry);
    int ax, ay, bx, by, lam, cx, cy;
    logic ia, ib;
    ia = (x1 == ALL1);
    ib = (x2 == ALL1);
    ax = int'(x1[7:0]); ay = int'(y1[7:0]);
    bx = int'(x2[7:0]); by = int'(y2[7:0]);
    rx = ALL1; ry = ALL1;
    if (op == 1'b0 || (add && !ia && !ib && ax == bx && ay == by)) begin
      if (!ia && ay != 0) begin
        lam = md((3 * ax * ax + 2) * inv(2 * ay));
        cx  = md(lam * lam - 2 * ax);
        cy  = md(lam * (ax - cx) - ay);
        rx = W'(cx); ry = W'(cy);
      end
    end else if (!add) begin
      rx = x1; ry = y1;
    end else if (ia) begin
      rx = x2; ry = y2;
    end else if (ib) begin
      rx = x1; ry = y1;
    end else if (ax != bx) begin
      lam = md((by - ay) * inv(bx - ax));
      cx  = md(lam * lam - ax - bx);
      cy  = md(lam * (ax - cx) - ay);
      rx = W'(cx); ry = W'(cy);
    end
  endtask

  // Point-unit model state and request log.
  int           pend  = 0;
  int           n_req = 0;
  logic         m_op, m_add;
  logic [W-1:0] m_x1, m_y1, m_x2, m_y2;
  logic         log_op  [16];
  logic         log_add [16];

  initial begin
    pa_fin = 1'b0; pa_x = '0; pa_y = '0;
    forever begin
      @(negedge clk);
      pa_fin = 1'b0;
      if (pend > 0) begin
        if (busy) begin
          chk("pa_x1_stable", pa_x1, m_x1);
          chk("pa_x2_stable", pa_x2, m_x2);
        end
        pend--;
        if (pend == 0) begin
          unit_calc(m_op, m_add, m_x1, m_y1, m_x2, m_y2, pa_x, pa_y);
          pa_fin = 1'b1;
        end
      end
      if (pa_start) begin
        chk("pa_start_while_pending", W'(pend), W'(0));
        m_op = pa_op; m_add = pa_add;
        m_x1 = pa_x1; m_y1 = pa_y1; m_x2 = pa_x2; m_y2 = pa_y2;
        if (n_req < 16) begin
          log_op[n_req]  = pa_op;
          log_add[n_req] = pa_add;
        end
        n_req++;
        pend = 5;
      end
    end
  end

  task automatic start_op(input logic [W-1:0] kk, input logic [W-1:0] xx, input logic [W-1:0] yy);
    n_req = 0;
    @(negedge clk);
    start = 1'b1; k = kk; x = xx; y = yy;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = negedges from the start edge to the one showing o_finish.
  task automatic wait_finish(input int first, output int cyc);
    cyc = first;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("finish_seen", W'(fin), W'(1));
    chk("busy_at_finish", W'(busy), W'(1));
  endtask

  task automatic idle_after;
    @(negedge clk);
    chk("busy_cleared", W'(busy), W'(0));
    chk("finish_one_cycle", W'(fin), W'(0));
  endtask

  initial begin
    int cyc;
    int t;
    int fin_seen;
    logic [7:0] seq;
    rst = 1'b1; start = 1'b0; k = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_finish", W'(fin), W'(0));
    chk("rst_res_x", res_x, '0);
    chk("rst_res_y", res_y, '0);
    chk("rst_inf", W'(inf), W'(0));
    chk("rst_pa_start", W'(pa_start), W'(0));
    chk("rst_pa_add", W'(pa_add), W'(0));
    chk("rst_pa_x1", pa_x1, '0);
    rst = 1'b0;

    // k = 0: straight to DONE, infinity, no requests.
    start_op(W'(0), W'(5), W'(1));
    chk("k0_busy", W'(busy), W'(1));
    wait_finish(1, cyc);
    chk("k0_latency", W'(cyc), W'(2));
    chk("k0_inf", W'(inf), W'(1));
    chk("k0_res_x", res_x, ALL1);
    chk("k0_res_y", res_y, ALL1);
    chk("k0_nreq", W'(n_req), W'(0));
    idle_after();
    chk("k0_hold_x", res_x, ALL1);

    // k = 1: result P, no requests, 2 + 192 cycles.
    start_op(W'(1), W'(5), W'(1));
    wait_finish(1, cyc);
    chk("k1_latency", W'(cyc), W'(194));
    chk("k1_res_x", res_x, W'(5));
    chk("k1_res_y", res_y, W'(1));
    chk("k1_inf", W'(inf), W'(0));
    chk("k1_nreq", W'(n_req), W'(0));
    idle_after();

    // k = 5: D,A(0),D,A(1) -> 5P = (9,16).
    start_op(W'(5), W'(5), W'(1));
    wait_finish(1, cyc);
    chk("k5_latency", W'(cyc), W'(216));
    chk("k5_res_x", res_x, W'(9));
    chk("k5_res_y", res_y, W'(16));
    chk("k5_inf", W'(inf), W'(0));
    chk("k5_nreq", W'(n_req), W'(4));
    seq = '0;
    for (int i = 0; i < 4; i++) seq = {seq[5:0], log_op[i], log_add[i]};
    chk("k5_op_log", W'(seq), W'(8'b01_10_01_11));
    idle_after();

    // k = 19 (group order): infinity after 8 requests.
    start_op(W'(19), W'(5), W'(1));
    wait_finish(1, cyc);
    chk("k19_inf", W'(inf), W'(1));
    chk("k19_res_x", res_x, ALL1);
    chk("k19_res_y", res_y, ALL1);
    chk("k19_nreq", W'(n_req), W'(8));
    idle_after();

    // Start pulsed during DBL_WAIT with another k is ignored.
    start_op(W'(5), W'(5), W'(1));
    t = 0;
    while (n_req < 1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("ign_req_seen", W'(n_req >= 1), W'(1));
    @(negedge clk);
    start = 1'b1; k = W'(19);
    @(negedge clk);
    start = 1'b0;
    wait_finish(0, cyc);
    chk("ign_res_x", res_x, W'(9));
    chk("ign_res_y", res_y, W'(16));
    chk("ign_nreq", W'(n_req), W'(4));
    idle_after();

    // Reset during ADD_WAIT; the late unit finish must be ignored.
    start_op(W'(5), W'(5), W'(1));
    t = 0;
    while (n_req < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rst_req_seen", W'(n_req >= 2), W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fin_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fin) fin_seen++;
      if (pa_start) fin_seen++;
    end
    chk("mid_rst_no_finish", W'(fin_seen), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_res_x", res_x, '0);
    chk("mid_rst_res_y", res_y, '0);
    chk("mid_rst_inf", W'(inf), W'(0));

    // Fresh start after reset: 2P = (6,3).
    start_op(W'(2), W'(5), W'(1));
    wait_finish(1, cyc);
    chk("k2_res_x", res_x, W'(6));
    chk("k2_res_y", res_y, W'(3));
    chk("k2_nreq", W'(n_req), W'(2));
    idle_after();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
